// File: rtl/and_gate.sv
// Purpose: bitwise two-input AND leaf cell with an optional registered/monitoring path.
// Latency: f is combinational (0 cycles); f_q, f_rise and hi_count are registered (1 cycle).
// Backpressure: none; inputs are sampled every cycle and en only gates the f_q update.
//
// Ports:
//   clk      - system clock, all state updates on its rising edge
//   rst_n    - synchronous active-low reset, takes priority over en
//   a, b     - WIDTH-bit operands
//   en       - update enable for the registered copy f_q
//   f        - a & b, combinational, independent of clk/rst_n/en
//   f_q      - registered copy of f, holds while en is low
//   f_rise   - one-cycle pulse after the edge where &f_q goes 0->1
//   hi_count - saturating count of cycles in which &f_q was 1
module and_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_q,
    output logic             f_rise,
    output logic [CNT_W-1:0] hi_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] f_q_nxt;
    logic             all_q;
    logic             all_nxt;
    logic             prev_hi;

    // Pure combinational path: must work with no clock activity at all.
    assign f = a & b;

    // Value f_q will take at the coming edge (outside reset).
    assign f_q_nxt = en ? f : f_q;

    // all_q is the level the counter looks at this cycle; all_nxt is the
    // level f_q will show after the edge, which is what f_rise reports on.
    assign all_q   = &f_q;
    assign all_nxt = &f_q_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q      <= '0;
            f_rise   <= 1'b0;
            hi_count <= '0;
            prev_hi  <= 1'b0;
        end else begin
            f_q     <= f_q_nxt;
            // prev_hi tracks &f_q one cycle behind, so the pulse fires only
            // on the edge where the reduced level actually turns on.
            f_rise  <= all_nxt & ~prev_hi;
            prev_hi <= all_nxt;
            // Counts the level present before this edge; sticks at max.
            if (all_q && (hi_count != CNT_MAX)) begin
                hi_count <= hi_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_and_gate.sv
module tb_and_gate;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst_n;
    logic       en;
    logic       a, b;
    logic [3:0] a4, b4;

    logic        f, f_q, f_rise;
    logic [15:0] hi_count;
    logic [3:0]  f4, f_q4;
    logic        f_rise4;
    logic [1:0]  hi_count4;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state (specification level: level history + plain counts)
    logic       m1_fq, m1_rise;
    int         m1_hits;
    logic [3:0] m4_fq;
    logic       m4_rise;
    int         m4_hits;

    and_gate #(.WIDTH(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en),
        .f(f), .f_q(f_q), .f_rise(f_rise), .hi_count(hi_count)
    );

    and_gate #(.WIDTH(4), .CNT_W(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .en(en),
        .f(f4), .f_q(f_q4), .f_rise(f_rise4), .hi_count(hi_count4)
    );

    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model: on each edge, a cycle with every bit of the old f_q high counts
    // as a hit; f_q loads a&b when enabled; a rise is old-low, new-high.
    always @(posedge clk) begin
        logic old1, old4;
        if (!rst_n) begin
            m1_fq = 1'b0; m1_rise = 1'b0; m1_hits = 0;
            m4_fq = 4'h0; m4_rise = 1'b0; m4_hits = 0;
        end else begin
            old1 = m1_fq;
            old4 = (m4_fq == 4'hF);
            if (old1) m1_hits = m1_hits + 1;
            if (old4) m4_hits = m4_hits + 1;
            if (en) begin
                m1_fq = a & b;
                m4_fq = a4 & b4;
            end
            m1_rise = m1_fq && !old1;
            m4_rise = (m4_fq == 4'hF) && !old4;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_f",       32'(f),         32'(a & b));
            check("cyc_f_q",     32'(f_q),       32'(m1_fq));
            check("cyc_f_rise",  32'(f_rise),    32'(m1_rise));
            check("cyc_hi",      32'(hi_count),  (m1_hits > 65535) ? 32'd65535 : 32'(m1_hits));
            check("cyc_f4",      32'(f4),        32'(a4 & b4));
            check("cyc_f_q4",    32'(f_q4),      32'(m4_fq));
            check("cyc_f_rise4", 32'(f_rise4),   32'(m4_rise));
            check("cyc_hi4",     32'(hi_count4), (m4_hits > 3) ? 32'd3 : 32'(m4_hits));
        end
    end

    typedef struct {
        logic a;
        logic b;
        logic f;
    } tt_t;

    tt_t tt[4] = '{'{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0},
                   '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b1}};

    initial begin
        rst_n = 1'b0; en = 1'b0; a = 1'b0; b = 1'b0; a4 = 4'h0; b4 = 4'h0;

        // Truth table with the clock idle
        for (int i = 0; i < 4; i++) begin
            a = tt[i].a; b = tt[i].b;
            #10;
            check("tt_f", 32'(f), 32'(tt[i].f));
        end
        a4 = 4'b1100; b4 = 4'b1010;
        #10;
        check("tt_f4_idle", 32'(f4), 32'h8);

        // Reset held over two edges with everything asserted
        a = 1'b1; b = 1'b1; en = 1'b1; a4 = 4'h0; b4 = 4'h0;
        clk_run = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_f_q",    32'(f_q),      32'h0);
            check("rst_f_rise", 32'(f_rise),   32'h0);
            check("rst_hi",     32'(hi_count), 32'h0);
            check("rst_f",      32'(f),        32'h1);
        end
        chk_en = 1'b1;

        // Registered path after release
        rst_n = 1'b1;
        step();
        check("reg_f_q_e1",  32'(f_q),      32'h1);
        check("reg_rise_e1", 32'(f_rise),   32'h1);
        check("reg_hi_e1",   32'(hi_count), 32'h0);
        step();
        check("reg_rise_e2", 32'(f_rise),   32'h0);
        check("reg_hi_e2",   32'(hi_count), 32'h1);
        step();
        check("reg_hi_e3",   32'(hi_count), 32'h2);

        // Enable hold
        en = 1'b0; a = 1'b0;
        #1;
        check("hold_f_now",  32'(f),        32'h0);
        step();
        check("hold_f_q",    32'(f_q),      32'h1);
        check("hold_hi_e1",  32'(hi_count), 32'h3);
        step();
        check("hold_hi_e2",  32'(hi_count), 32'h4);

        // Reset mid-operation, then restart
        rst_n = 1'b0;
        step();
        check("mid_rst_f_q", 32'(f_q),      32'h0);
        check("mid_rst_hi",  32'(hi_count), 32'h0);
        check("mid_rst_f",   32'(f),        32'h0);
        rst_n = 1'b1; en = 1'b1; a = 1'b1;
        step();
        check("restart_f_q",  32'(f_q),    32'h1);
        check("restart_rise", 32'(f_rise), 32'h1);

        // Saturation on the 2-bit counter instance
        a4 = 4'hF; b4 = 4'hF;
        step();
        check("sat_rise4", 32'(f_rise4), 32'h1);
        for (int i = 0; i < 5; i++) step();
        check("sat_hi4_6", 32'(hi_count4), 32'h3);
        step();
        check("sat_hi4_7", 32'(hi_count4), 32'h3);

        // Partial AND on the wide instance
        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        check("w4_f", 32'(f4), 32'h8);
        step();
        check("w4_f_q",  32'(f_q4),      32'h8);
        check("w4_rise", 32'(f_rise4),   32'h0);
        check("w4_hi",   32'(hi_count4), 32'h3);
        step();
        check("w4_hi_after", 32'(hi_count4), 32'h3);

        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/and_gate.md
Name: and_gate

Overview:
Bitwise two-input AND primitive with a purely combinational output, plus an optional registered/monitoring path for synchronous consumers. It is used as a leaf cell in datapath glue logic. The combinational output works even when the clock and reset are idle or undriven. The clocked path adds a registered copy, a rising-edge pulse and a saturating activity counter.

Parameters:
WIDTH, 1, bit width of a, b, f and f_q (bitwise AND per bit)
CNT_W, 16, width of the hi_count activity counter

Ports:
clk  input  1  single system clock; all sequential logic on posedge clk
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
a  input  WIDTH  operand A
b  input  WIDTH  operand B
en  input  1  register-update enable for the clocked path
f  output  WIDTH  combinational result a & b
f_q  output  WIDTH  registered copy of f
f_rise  output  1  one-cycle pulse when &f_q goes 0->1
hi_count  output  CNT_W  saturating count of cycles with &f_q == 1

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- f = a & b, bitwise and purely combinational, with zero latency.
- f does not depend on clk, rst_n or en. f is valid within the same delta/time step as input changes, even if clk never toggles.
- X/Z inputs: standard 4-state AND rules apply. 0 & X = 0; 1 & X = X.
- Reset: on posedge clk with rst_n == 0, the following clear, and reset has priority over en:
  - f_q <= 0
  - f_rise <= 0
  - hi_count <= 0
  - the internal prev-state flag <= 0
- Registered path: on posedge clk with rst_n == 1 and en == 1, f_q <= a & b. When en == 0, f_q holds its value.
- Latency: f_q reflects inputs sampled at edge N, visible after edge N. This is 1 cycle.
- f_rise: registered. It is 1 for exactly one cycle after the edge on which &f_q transitions 0->1, compared against the previous cycle's &f_q. It is 0 otherwise, including when &f_q stays high.
- hi_count: increments by 1 on every posedge (rst_n == 1) where the current &f_q == 1. It saturates at 2^CNT_W - 1 and does not wrap.
- hi_count counts cycles regardless of en, since f_q holds its value when en == 0.
- Reset asserted mid-operation: all registered outputs return to 0 on the next edge. f continues to track a & b.
- Simultaneous reset and en: reset wins.
- Simultaneous rise and saturation: f_rise still pulses; hi_count stays at max.

Test Plan:
- Truth table with no clock activity, holding each vector 10 ns: (a,b)=(0,0)->f=0; (0,1)->f=0; (1,0)->f=0; (1,1)->f=1.
- Reset: hold rst_n=0 for 2 edges with a=b=1, en=1 -> f_q=0, f_rise=0, hi_count=0, while f=1 throughout.
- Registered path: release reset, a=b=1, en=1 -> after 1 edge f_q=1 and f_rise=1 for one cycle. hi_count=1 after the next edge, then increments each cycle.
- Enable hold: set en=0 with f_q=1, then drive a=0 -> f=0 immediately, f_q stays 1, hi_count keeps incrementing.
- Saturation: CNT_W=2, keep &f_q=1 for 6 cycles -> hi_count reaches 3 and stays at 3.
- WIDTH=4: a=4'b1100, b=4'b1010 -> f=4'b1000. Clock with en=1 -> f_q=4'b1000, f_rise=0, hi_count unchanged.
